// File: rtl/fleet_pkg.sv
// Shared definitions for the enemy fleet: coordinate types, FSM states and
// default tuning constants.
package fleet_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_x_t;  // one spare bit so hitbox sums never wrap

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MOVE_RIGHT,
    ST_MOVE_LEFT,
    ST_MOVE_DOWN,
    ST_WIN,
    ST_LOSE
  } fleet_state_e;

  localparam int unsigned DEF_N_ENEMIES   = 3;
  localparam int unsigned DEF_SPACING_H   = 150;
  localparam int unsigned DEF_STEP_H      = 50;
  localparam int unsigned DEF_STEP_V      = 50;
  localparam int unsigned DEF_LEFT_BOUND  = 175;
  localparam int unsigned DEF_RIGHT_BOUND = 400;
  localparam int unsigned DEF_START_V     = 65;
  localparam int unsigned DEF_LOSE_V      = 475;
  localparam int unsigned DEF_HIT_W       = 32;
  localparam int unsigned DEF_HIT_H       = 32;
  localparam int unsigned DEF_PERIOD_BASE = 32'd1 << 27;
  localparam int unsigned DEF_PERIOD_DEC  = 32'd1 << 24;
  localparam int unsigned DEF_PERIOD_MIN  = 32'd1 << 23;

endpackage

// File: rtl/enemy_hitbox.sv
// Combinational point-in-box test for a single enemy.
module enemy_hitbox
  import fleet_pkg::*;
#(
  parameter int unsigned HIT_W = DEF_HIT_W,
  parameter int unsigned HIT_H = DEF_HIT_H
) (
  input  logic [COORD_W:0]   box_h,
  input  logic [COORD_W-1:0] box_v,
  input  logic [COORD_W-1:0] proj_h,
  input  logic [COORD_W-1:0] proj_v,
  output logic               hit
);

  coord_x_t ph, pv, bv;

  assign ph = {1'b0, proj_h};
  assign pv = {1'b0, proj_v};
  assign bv = {1'b0, box_v};

  assign hit = (ph >= box_h) && (ph < box_h + coord_x_t'(HIT_W)) &&
               (pv >= bv)    && (pv < bv + coord_x_t'(HIT_H));

endmodule

// File: rtl/enemy_grid.sv
// Row of enemies marching left/right and descending, with projectile kills,
// speed-up per kill and win/lose detection.
module enemy_grid
  import fleet_pkg::*;
#(
  parameter int unsigned N_ENEMIES   = DEF_N_ENEMIES,
  parameter int unsigned SPACING_H   = DEF_SPACING_H,
  parameter int unsigned STEP_H      = DEF_STEP_H,
  parameter int unsigned STEP_V      = DEF_STEP_V,
  parameter int unsigned LEFT_BOUND  = DEF_LEFT_BOUND,
  parameter int unsigned RIGHT_BOUND = DEF_RIGHT_BOUND,
  parameter int unsigned START_V     = DEF_START_V,
  parameter int unsigned LOSE_V      = DEF_LOSE_V,
  parameter int unsigned HIT_W       = DEF_HIT_W,
  parameter int unsigned HIT_H       = DEF_HIT_H,
  parameter int unsigned PERIOD_BASE = DEF_PERIOD_BASE,
  parameter int unsigned PERIOD_DEC  = DEF_PERIOD_DEC,
  parameter int unsigned PERIOD_MIN  = DEF_PERIOD_MIN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 proj_valid,
  input  logic [COORD_W-1:0]   proj_h,
  input  logic [COORD_W-1:0]   proj_v,
  output logic [COORD_W-1:0]   fleet_h,
  output logic [COORD_W-1:0]   fleet_v,
  output logic [N_ENEMIES-1:0] alive,
  output logic                 hit_pulse,
  output logic [2:0]           hit_index,
  output logic                 win,
  output logic                 lose
);

  fleet_state_e         state_q;
  coord_t               fleet_h_q, fleet_v_q;
  logic [N_ENEMIES-1:0] alive_q;
  logic                 hit_pulse_q, win_q, lose_q, dir_left_q;
  logic [2:0]           hit_index_q;
  logic [31:0]          tick_q;

  logic [N_ENEMIES-1:0] hit_vec, kill_mask;
  logic                 kill_any, hit_en, load_init, can_right, can_left;
  logic [2:0]           kill_idx;
  logic [3:0]           kills;
  logic [63:0]          dec_total, period;

  for (genvar g = 0; g < N_ENEMIES; g++) begin : g_box
    coord_x_t box_h;
    logic     in_box;
    assign box_h = coord_x_t'(fleet_h_q) + coord_x_t'(g * SPACING_H);
    enemy_hitbox #(.HIT_W(HIT_W), .HIT_H(HIT_H)) u_hitbox (
      .box_h  (box_h),
      .box_v  (fleet_v_q),
      .proj_h (proj_h),
      .proj_v (proj_v),
      .hit    (in_box)
    );
    assign hit_vec[g] = in_box & alive_q[g] & proj_valid;
  end

  // Only the lowest-indexed hit enemy dies; the rest survive this cycle.
  always_comb begin
    kill_any  = 1'b0;
    kill_idx  = '0;
    kill_mask = '0;
    kills     = '0;
    for (int unsigned i = 0; i < N_ENEMIES; i++) begin
      if (hit_vec[i] && !kill_any) begin
        kill_any     = 1'b1;
        kill_idx     = 3'(i);
        kill_mask[i] = 1'b1;
      end
      if (!alive_q[i]) kills = kills + 4'd1;
    end
  end

  assign dec_total = 64'(kills) * 64'(PERIOD_DEC);
  assign period    = (64'(PERIOD_BASE) < dec_total + 64'(PERIOD_MIN)) ?
                     64'(PERIOD_MIN) : 64'(PERIOD_BASE) - dec_total;

  assign hit_en    = (state_q == ST_IDLE) || (state_q == ST_MOVE_RIGHT) ||
                     (state_q == ST_MOVE_LEFT) || (state_q == ST_MOVE_DOWN);
  assign load_init = (state_q == ST_INIT) ||
                     (((state_q == ST_WIN) || (state_q == ST_LOSE)) && start);
  assign can_right = coord_x_t'(fleet_h_q) + coord_x_t'(STEP_H) <= coord_x_t'(RIGHT_BOUND);
  assign can_left  = coord_x_t'(fleet_h_q) >= coord_x_t'(LEFT_BOUND) + coord_x_t'(STEP_H);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      fleet_h_q   <= coord_t'(LEFT_BOUND);
      fleet_v_q   <= coord_t'(START_V);
      alive_q     <= '1;
      hit_pulse_q <= 1'b0;
      hit_index_q <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      tick_q      <= '0;
      dir_left_q  <= 1'b0;
    end else begin
      hit_pulse_q <= 1'b0;
      if (load_init) begin
        fleet_h_q  <= coord_t'(LEFT_BOUND);
        fleet_v_q  <= coord_t'(START_V);
        alive_q    <= '1;
        win_q      <= 1'b0;
        lose_q     <= 1'b0;
        tick_q     <= '0;
        dir_left_q <= 1'b0;
      end
      if (hit_en && kill_any) begin
        alive_q     <= alive_q & ~kill_mask;
        hit_pulse_q <= 1'b1;
        hit_index_q <= kill_idx;
      end
      unique case (state_q)
        ST_INIT: if (start) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (alive_q == '0) begin
            state_q <= ST_WIN;
            win_q   <= 1'b1;
          end else if (fleet_v_q > coord_t'(LOSE_V)) begin
            state_q <= ST_LOSE;
            lose_q  <= 1'b1;
          end else if (64'(tick_q) == period - 64'd1) begin
            tick_q <= '0;
            if (!dir_left_q && can_right)     state_q <= ST_MOVE_RIGHT;
            else if (dir_left_q && can_left)  state_q <= ST_MOVE_LEFT;
            else begin
              state_q    <= ST_MOVE_DOWN;
              dir_left_q <= !dir_left_q;
            end
          end else begin
            tick_q <= tick_q + 32'd1;
          end
        end
        ST_MOVE_RIGHT, ST_MOVE_LEFT, ST_MOVE_DOWN: begin
          // A kill that emptied the fleet on the entry edge pre-empts the step.
          if (alive_q == '0) begin
            state_q <= ST_WIN;
            win_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            if (state_q == ST_MOVE_RIGHT)     fleet_h_q <= fleet_h_q + coord_t'(STEP_H);
            else if (state_q == ST_MOVE_LEFT) fleet_h_q <= fleet_h_q - coord_t'(STEP_H);
            else                              fleet_v_q <= fleet_v_q + coord_t'(STEP_V);
          end
        end
        ST_WIN, ST_LOSE: if (start) state_q <= ST_INIT;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign fleet_h   = fleet_h_q;
  assign fleet_v   = fleet_v_q;
  assign alive     = alive_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_index = hit_index_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: doc/enemy_grid.md
ENEMY_GRID -- requirements
Module: enemy_grid

Interface
REQ-001 SHALL have parameter N_ENEMIES, default 3: enemies in the row (1..8).
REQ-002 SHALL have parameter SPACING_H, default 150: horizontal pixel pitch between adjacent enemies.
REQ-003 SHALL have parameters STEP_H=50 and STEP_V=50: lateral and descent step in pixels.
REQ-004 SHALL have parameters LEFT_BOUND=175, RIGHT_BOUND=400, START_V=65 and LOSE_V=475: fleet-origin limits.
REQ-005 SHALL have parameters HIT_W=32 and HIT_H=32: enemy hitbox size in pixels.
REQ-006 SHALL have parameters PERIOD_BASE=2^27, PERIOD_DEC=2^24 and PERIOD_MIN=2^23: move period in cycles.
REQ-007 SHALL have port clk, input, 1: the single clock.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: leaves INIT, WIN or LOSE.
REQ-010 SHALL have port proj_valid, input, 1: projectile in flight.
REQ-011 SHALL have ports proj_h and proj_v, input, 10 each: projectile pixel position.
REQ-012 SHALL have ports fleet_h and fleet_v, output, 10 each: origin of enemy 0.
REQ-013 SHALL have port alive, output, N_ENEMIES: per-enemy alive mask.
REQ-014 SHALL have port hit_pulse, output, 1: one-cycle strobe when a kill is applied.
REQ-015 SHALL have port hit_index, output, 3: index of the last killed enemy.
REQ-016 SHALL have ports win and lose, output, 1 each: sticky game-outcome flags.

Function
REQ-017 SHALL implement states INIT, IDLE, MOVE_RIGHT, MOVE_LEFT, MOVE_DOWN, WIN and LOSE.
REQ-018 In INIT: fleet_h=LEFT_BOUND, fleet_v=START_V, alive=all ones, direction=right, tick counter=0; start=1 moves to IDLE on the next edge.
REQ-019 In IDLE, the tick counter SHALL increment each cycle; on reaching period-1 it SHALL clear and select the move state.
REQ-020 Move selection: right and fleet_h+STEP_H<=RIGHT_BOUND -> MOVE_RIGHT; right otherwise -> MOVE_DOWN and set direction=left; left and fleet_h>=LEFT_BOUND+STEP_H -> MOVE_LEFT; left otherwise -> MOVE_DOWN and set direction=right.
REQ-021 Each move state SHALL apply exactly one step in one cycle and then return to IDLE.
REQ-022 The move period SHALL be max(PERIOD_MIN, PERIOD_BASE - kills*PERIOD_DEC), where kills = number of zero bits in alive.
REQ-023 Enemy i SHALL span h in [fleet_h+i*SPACING_H, +HIT_W) and v in [fleet_v, +HIT_H); all hitbox sums SHALL be computed at 11 bits with no wrap.
REQ-024 An enemy is hit when proj_valid=1, alive[i]=1 and the projectile lies in its box; hits SHALL be evaluated only in IDLE and the move states.
REQ-025 On a hit, the next edge SHALL clear alive[i], assert hit_pulse for exactly one cycle and load hit_index=i.
REQ-026 If several enemies are hit in the same cycle, only the lowest index SHALL be killed; the others remain alive.
REQ-027 When alive becomes zero, the FSM SHALL enter WIN on the following edge and set win=1.
REQ-028 If fleet_v > LOSE_V after a MOVE_DOWN, the FSM SHALL enter LOSE on the next edge and set lose=1.
REQ-029 If win and lose conditions coincide, win SHALL take priority.
REQ-030 WIN and LOSE SHALL hold all outputs frozen; start=1 SHALL go to INIT, which clears win and lose.
REQ-031 A kill and a move occurring in the same cycle SHALL both take effect.

Reset
REQ-032 While reset=1 at an edge: state=INIT, fleet_h=LEFT_BOUND, fleet_v=START_V, alive=all ones, hit_pulse=0, hit_index=0, win=0, lose=0, tick counter=0, direction=right.
REQ-033 Reset asserted mid-move or mid-hit SHALL discard any pending kill or step.

Structure
REQ-034 Package fleet_pkg SHALL hold the state enum, the default parameter constants and the coordinate width (10).
REQ-035 Sub-module enemy_hitbox (combinational box-compare of one enemy) SHALL be instantiated N_ENEMIES times via generate.

Verification
REQ-036 Reset, start, N=3, no projectile -> first MOVE_RIGHT at PERIOD_BASE cycles after IDLE entry; fleet_h sequence 175, 225 ... 375, then fleet_v 65->115 with direction=left.
REQ-037 Projectile (340,70) held while fleet_h=175 and fleet_v=65 -> alive 111->101, hit_pulse for 1 cycle, hit_index=1; next period = 2^27-2^24.
REQ-038 Hitboxes of enemies 0 and 1 overlapping with SPACING_H=20 and projectile (200,70) -> only enemy 0 killed.
REQ-039 Kill all three enemies -> win=1 one edge after alive=000; win holds until start -> INIT -> alive=111.
REQ-040 Small periods, no hits -> lose=1 after the descent that makes fleet_v=515; reset asserted during MOVE_DOWN -> fleet_v=65 and state=INIT.
